// File: rtl/life_pkg.sv
// Shared definitions for the player-life tracker and the HUD icon decoder.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package life_pkg;

    typedef enum logic [2:0] {
        ALIVE,
        DYING,
        RESPAWN,
        INVULN,
        GAME_OVER
    } life_fsm_t;

    // HUD spare-life icon codes; the HUD decoder relies on these exact values
    localparam logic [1:0] LS_TWO_SPARE = 2'b00;
    localparam logic [1:0] LS_ONE_SPARE = 2'b01;
    localparam logic [1:0] LS_NO_SPARE  = 2'b10;

    // Map a spare-life count (0..2) onto the HUD code
    function automatic logic [1:0] spare_to_ls(input logic [1:0] spare);
        case (spare)
            2'd2:    spare_to_ls = LS_TWO_SPARE;
            2'd1:    spare_to_ls = LS_ONE_SPARE;
            default: spare_to_ls = LS_NO_SPARE;
        endcase
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Counts enabled frame ticks up to a limit and flags the tick that reaches it.
// Latency: done is combinational on the reaching tick; count updates on the next edge.
// Backpressure: none; clear overrides enable so a tick in a clearing cycle is dropped.
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // The tick that takes the count to the limit is the terminating one
    assign done = enable && !clear && (count == limit - 1'b1);

    // Frame counter: cleared outside the timed phases, bumped once per tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // While a timed phase is running the count never passes its limit (no wrap)
    assert property (@(posedge clk) disable iff (rst) !clear |-> (count <= limit));

endmodule

// File: rtl/life_tracker.sv
// Owns player lives: death animation, respawn, invulnerability window and game over.
// Latency: all outputs registered, they change on the edge that samples the causing input.
// Backpressure: none; hits outside ALIVE are dropped, never queued; new_game wins over all.
module life_tracker
    import life_pkg::*;
#(
    parameter int DEATH_FRAMES  = 90,
    parameter int INVULN_FRAMES = 60,
    parameter int CNT_W         = 7
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic       player_hit,
    input  logic       new_game,
    output logic [1:0] life_state,
    output logic       dying,
    output logic       respawn,
    output logic       invuln,
    output logic       game_over
);

    localparam logic [CNT_W-1:0] DEATH_LIM  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0] INVULN_LIM = CNT_W'(INVULN_FRAMES);

    life_fsm_t        state;
    logic [1:0]       spare;
    logic             timer_clear;
    logic [CNT_W-1:0] timer_limit;
    logic             timer_done;

    // The single timer only runs in DYING and INVULN; every other state holds it at zero
    assign timer_clear = new_game || !((state == DYING) || (state == INVULN));
    assign timer_limit = (state == INVULN) ? INVULN_LIM : DEATH_LIM;

    frame_timer #(
        .CNT_W (CNT_W)
    ) u_frame_timer (
        .clk    (Clk),
        .rst    (Reset),
        .clear  (timer_clear),
        .enable (frame_tick),
        .limit  (timer_limit),
        .done   (timer_done)
    );

    // Life FSM with spare count and Moore outputs registered alongside the state
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= ALIVE;
            spare      <= 2'd2;
            life_state <= LS_TWO_SPARE;
            dying      <= 1'b0;
            respawn    <= 1'b0;
            invuln     <= 1'b0;
            game_over  <= 1'b0;
        end else if (new_game) begin
            state      <= ALIVE;
            spare      <= 2'd2;
            life_state <= LS_TWO_SPARE;
            dying      <= 1'b0;
            respawn    <= 1'b0;
            invuln     <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            respawn <= 1'b0;
            case (state)
                ALIVE: begin
                    if (player_hit) begin
                        state <= DYING;
                        dying <= 1'b1;
                    end
                end
                DYING: begin
                    if (timer_done) begin
                        dying <= 1'b0;
                        if (spare == 2'd0) begin
                            state     <= GAME_OVER;
                            game_over <= 1'b1;
                        end else begin
                            // HUD icon drops on the same edge the respawn pulse rises
                            state      <= RESPAWN;
                            respawn    <= 1'b1;
                            spare      <= spare - 2'd1;
                            life_state <= spare_to_ls(spare - 2'd1);
                        end
                    end
                end
                RESPAWN: begin
                    state  <= INVULN;
                    invuln <= 1'b1;
                end
                INVULN: begin
                    if (timer_done) begin
                        state  <= ALIVE;
                        invuln <= 1'b0;
                    end
                end
                GAME_OVER: begin
                    state <= GAME_OVER;
                end
                default: begin
                    state     <= ALIVE;
                    dying     <= 1'b0;
                    invuln    <= 1'b0;
                    game_over <= 1'b0;
                end
            endcase
        end
    end

    // Frame limits must survive truncation to the counter width
    assert property (@(posedge Clk) disable iff (Reset)
        (DEATH_FRAMES < (1 << CNT_W)) && (INVULN_FRAMES < (1 << CNT_W)));

endmodule

// File: tb/tb_life_tracker.sv
// Directed plus random stimulus against a frame-countdown model of the life rules.
// Latency: model advances once per sampled clock edge, outputs compared 1 time unit later.
// Backpressure: n/a.
module tb_life_tracker;

    localparam int DEATH  = 3;
    localparam int INVULN = 2;

    localparam int M_ALIVE   = 0;
    localparam int M_DYING   = 1;
    localparam int M_RESPAWN = 2;
    localparam int M_INVULN  = 3;
    localparam int M_OVER    = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_tick;
    logic       player_hit;
    logic       new_game;
    logic [1:0] life_state;
    logic       dying;
    logic       respawn;
    logic       invuln;
    logic       game_over;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: lives left, current phase and frames still to go in it
    int m_mode;
    int m_spare;
    int m_left;

    life_tracker #(
        .DEATH_FRAMES  (DEATH),
        .INVULN_FRAMES (INVULN),
        .CNT_W         (7)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_tick (frame_tick),
        .player_hit (player_hit),
        .new_game   (new_game),
        .life_state (life_state),
        .dying      (dying),
        .respawn    (respawn),
        .invuln     (invuln),
        .game_over  (game_over)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_ALIVE;
        m_spare = 2;
        m_left  = 0;
    endtask

    task automatic model_clock(input bit hit, input bit tick, input bit ng);
        if (ng) begin
            m_mode  = M_ALIVE;
            m_spare = 2;
        end else begin
            case (m_mode)
                M_ALIVE: if (hit) begin
                    m_mode = M_DYING;
                    m_left = DEATH;
                end
                M_DYING: if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        if (m_spare == 0) m_mode = M_OVER;
                        else begin
                            m_spare = m_spare - 1;
                            m_mode  = M_RESPAWN;
                        end
                    end
                end
                M_RESPAWN: begin
                    m_mode = M_INVULN;
                    m_left = INVULN;
                end
                M_INVULN: if (tick) begin
                    m_left = m_left - 1;
                    if (m_left == 0) m_mode = M_ALIVE;
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_ls;
        exp_ls = 2'(2 - m_spare);
        check({tag, ".life_state"}, life_state, exp_ls);
        check({tag, ".dying"},      {1'b0, dying},     {1'b0, m_mode == M_DYING});
        check({tag, ".respawn"},    {1'b0, respawn},   {1'b0, m_mode == M_RESPAWN});
        check({tag, ".invuln"},     {1'b0, invuln},    {1'b0, m_mode == M_INVULN});
        check({tag, ".game_over"},  {1'b0, game_over}, {1'b0, m_mode == M_OVER});
    endtask

    // One clock of stimulus: drive at negedge, model on posedge, compare just after
    task automatic step(input string tag, input bit hit, input bit tick, input bit ng);
        player_hit = hit;
        frame_tick = tick;
        new_game   = ng;
        @(posedge Clk);
        model_clock(hit, tick, ng);
        #1;
        check_all(tag);
        @(negedge Clk);
        player_hit = 1'b0;
        frame_tick = 1'b0;
        new_game   = 1'b0;
    endtask

    task automatic apply_reset();
        Reset = 1'b1;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        Reset      = 1'b1;
        frame_tick = 1'b0;
        player_hit = 1'b0;
        new_game   = 1'b0;
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        check_all("reset");
        check("reset.life_state_const", life_state, 2'b00);

        // 1: hit, three ticks of death animation, respawn with one spare left
        step("t1.hit", 1, 0, 0);
        step("t1.tick1", 0, 1, 0);
        step("t1.idle", 0, 0, 0);
        step("t1.tick2", 0, 1, 0);
        step("t1.tick3", 0, 1, 0);
        check("t1.respawn_pulse", {1'b0, respawn}, 2'b01);
        check("t1.life_state_01", life_state, 2'b01);
        step("t1.to_invuln", 0, 0, 0);
        check("t1.invuln", {1'b0, invuln}, 2'b01);

        // 2: hits during INVULN are dropped, two ticks return to ALIVE
        step("t2.hit_inv", 1, 0, 0);
        step("t2.hit_tick", 1, 1, 0);
        step("t2.tick", 0, 1, 0);
        step("t2.alive", 0, 0, 0);
        check("t2.life_state_kept", life_state, 2'b01);
        // hits in DYING are dropped as well
        step("t2.hit", 1, 0, 0);
        step("t2.hit_dying", 1, 0, 0);
        step("t2.hit_tick_dying", 1, 1, 0);
        apply_reset();
        check_all("t2.reset");

        // 3: three full deaths from reset end in game over
        for (int d = 0; d < 3; d++) begin
            step("t3.hit", 1, 0, 0);
            for (int t = 0; t < DEATH; t++) step("t3.dtick", 0, 1, 0);
            if (d < 2) begin
                step("t3.resp", 0, 0, 0);
                for (int t = 0; t < INVULN; t++) step("t3.itick", 0, 1, 0);
            end
        end
        check("t3.game_over", {1'b0, game_over}, 2'b01);
        check("t3.no_respawn", {1'b0, respawn}, 2'b00);
        check("t3.life_state_10", life_state, 2'b10);

        // 4: game over ignores hits and ticks until new_game
        for (int f = 0; f < 10; f++) step("t4.hold", 1, 1, 0);
        step("t4.new_game", 0, 0, 1);
        check("t4.life_state_00", life_state, 2'b00);
        check("t4.game_over_clr", {1'b0, game_over}, 2'b00);

        // 5: new_game beats player_hit with one spare left
        step("t5.hit", 1, 0, 0);
        for (int t = 0; t < DEATH; t++) step("t5.dtick", 0, 1, 0);
        step("t5.resp", 0, 0, 0);
        for (int t = 0; t < INVULN; t++) step("t5.itick", 0, 1, 0);
        step("t5.ng_hit", 1, 0, 1);
        check("t5.life_state_00", life_state, 2'b00);
        check("t5.not_dying", {1'b0, dying}, 2'b00);

        // 6: asynchronous reset in the middle of DYING
        step("t6.hit", 1, 0, 0);
        step("t6.tick1", 0, 1, 0);
        step("t6.tick2", 0, 1, 0);
        #2;
        Reset = 1'b1;
        model_reset();
        #1;
        check_all("t6.async");
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        step("t6.tick_after", 0, 1, 0);
        step("t6.tick_after2", 0, 1, 0);
        check("t6.no_respawn", {1'b0, respawn}, 2'b00);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 39) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
